// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer and its controller/datapath.
// The master drives start and the datapath results; the slave is the sequencer.
interface fetch_sequencer_if;
  logic        start;
  logic [3:0]  opcode;
  logic        ex_done;
  logic        flag_eq;
  logic        flag_lt;
  logic [15:0] target;
  logic [15:0] pc;
  logic        fetch;
  logic        ex_start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] instr_count;

  modport master (
    output start, opcode, ex_done, flag_eq, flag_lt, target,
    input  pc, fetch, ex_start, busy, done, err, instr_count
  );

  modport slave (
    input  start, opcode, ex_done, flag_eq, flag_lt, target,
    output pc, fetch, ex_start, busy, done, err, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: fetch/execute handshake with jumps, conditional
// branches, halt and program-bound overrun detection.
module fetch_sequencer #(
  parameter int PROG_LEN = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.slave bus
);

  localparam logic [3:0]  OP_JMP  = 4'b0010;
  localparam logic [3:0]  OP_BNE  = 4'b1010;
  localparam logic [3:0]  OP_BEQ  = 4'b1011;
  localparam logic [3:0]  OP_BLT  = 4'b1100;
  localparam logic [3:0]  OP_HALT = 4'b1110;
  localparam logic [16:0] PROG_LEN_L = 17'(PROG_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic        first_q, first_d;

  logic [16:0] seq_addr;
  logic [16:0] next_addr;
  logic        taken;
  logic        overrun;
  logic        is_halt;

  // Sequential step is 17 bits wide so pc=FFFF+1 cannot wrap back into range.
  assign seq_addr = {1'b0, pc_q} + 17'd1;
  assign is_halt  = (bus.opcode == OP_HALT);

  always_comb begin
    taken = 1'b0;
    case (bus.opcode)
      OP_JMP:  taken = 1'b1;
      OP_BEQ:  taken = bus.flag_eq;
      OP_BNE:  taken = ~bus.flag_eq;
      OP_BLT:  taken = bus.flag_lt;
      default: taken = 1'b0;
    endcase
    next_addr = taken ? {1'b0, bus.target} : seq_addr;
  end

  assign overrun = (next_addr >= PROG_LEN_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    first_d = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end

      S_FETCH: begin
        state_d = S_EXEC;
        first_d = 1'b1;
      end

      S_EXEC: begin
        if (bus.ex_done) begin
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          // On halt or overrun pc keeps the address of the last retired instruction.
          if (is_halt) begin
            state_d = S_HALTED;
            err_d   = 1'b0;
          end else if (overrun) begin
            state_d = S_HALTED;
            err_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
            pc_d    = next_addr[15:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.fetch       = (state_q == S_FETCH);
  assign bus.ex_start    = (state_q == S_EXEC) && first_q;
  assign bus.busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign bus.done        = (state_q == S_HALTED);
  assign bus.err         = err_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer that drives the `pc` input of the instruction ROM/decoder and steps through the 8-bit-instruction program. It consumes the decoded opcode, the datapath's comparison flags and the register-supplied jump target. It runs a fetch/execute handshake with the datapath and handles jumps, conditional branches (BNE/BEQ/BLT), halt and program-bound overrun. It sits between the top-level start/done control and the instruction ROM + datapath.

## Interface
- `PROG_LEN`, 1024: number of valid instruction addresses; legal `pc` range is 0 to `PROG_LEN`-1; must be between 1 and 65536.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a run from address 0; honoured only in IDLE or HALTED.
- `opcode` input 4: decoded opcode for the instruction at `pc`; stable from the FETCH cycle through the end of EXEC.
- `ex_done` input 1: datapath has finished the current instruction; sampled only in EXEC.
- `flag_eq` input 1: operands equal, valid when `ex_done`=1.
- `flag_lt` input 1: operand1 < operand2, valid when `ex_done`=1.
- `target` input 16: absolute jump/branch address from the register file, valid when `ex_done`=1.
- `pc` output 16: current instruction address.
- `fetch` output 1: high for exactly the FETCH cycle.
- `ex_start` output 1: one-cycle pulse in the first EXEC cycle of each instruction.
- `busy` output 1: high in FETCH and EXEC.
- `done` output 1: high while HALTED.
- `err` output 1: high while HALTED if the halt was caused by overrun; cleared on the next start.
- `instr_count` output 16: instructions retired since last start; saturates at 16'hFFFF.

## Operation
- States: IDLE, FETCH, EXEC, HALTED. Encoding is free.
- IDLE: `pc`=0. On `start`=1, clear `instr_count` and go to FETCH.
- FETCH: lasts one cycle with `fetch`=1; the ROM decodes `pc`. Always goes to EXEC.
- EXEC: `ex_start`=1 in the first cycle only. Stay in EXEC while `ex_done`=0; there is no timeout. `ex_done` may already be high in the first EXEC cycle.
- Retire: on a cycle in EXEC with `ex_done`=1, increment `instr_count` (saturating), then select by opcode:
  - HALT (4'b1110): go to HALTED; `pc` unchanged; `err`=0.
  - JMP (4'b0010): next = `target`.
  - BEQ (4'b1011): next = `target` if `flag_eq`, else `pc`+1.
  - BNE (4'b1010): next = `target` if !`flag_eq`, else `pc`+1.
  - BLT (4'b1100): next = `target` if `flag_lt`, else `pc`+1.
  - All other opcodes, including TBA (4'b1111): next = `pc`+1.
- Overrun: `pc`+1 is computed 17 bits wide, so there is no wraparound.
  - If next >= `PROG_LEN` (taken branch or sequential step), go to HALTED with `err`=1; `pc` holds its old value.
  - Otherwise `pc` <= next and go to FETCH.
- HALTED: `done`=1, and `pc`, `instr_count` and `err` hold. On `start`=1: `pc`<=0, `instr_count`<=0, `err`<=0, go to FETCH.
- `start` is ignored in FETCH and EXEC.
- `flag_eq`, `flag_lt` and `target` are ignored outside the retire cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state = IDLE; `pc`=0, `instr_count`=0.
  - `fetch`=0, `ex_start`=0, `busy`=0, `done`=0, `err`=0.
- Reset during FETCH or EXEC aborts the instruction immediately; it is not retired or counted.
- All outputs are registered or decoded directly from state; there is no combinational path from any input to any output.
- Start to first `fetch`: `start` sampled at edge N gives FETCH in cycle N+1 and EXEC in cycle N+2.
- Minimum instruction period is 2 cycles (FETCH + one EXEC cycle with `ex_done`=1). The new `pc` is visible in the cycle after retire, together with `fetch`=1.
- `ex_start` never coincides with `fetch`. `ex_done` arriving in the same cycle as `ex_start` retires in that cycle.
- `done` and `err` rise in the cycle after the retire edge.
- `start` in the same cycle as an HALT retire is ignored; it must be reissued once `done`=1.

## Test plan
- Sequential run: opcodes ADD at pc 0–2, HALT at pc 3, `ex_done` held high -> `pc` sequence 0,1,2,3. `done`=1 with `pc`=3, `instr_count`=4, `err`=0. Each instruction takes 2 cycles.
- Branches: at pc 5, BEQ with `flag_eq`=1 and `target`=20 -> `pc`=20. Repeat with BEQ, `flag_eq`=0 -> `pc`=6. BNE, `flag_eq`=0 -> `target`. BLT, `flag_lt`=1 -> `target`. BLT, `flag_lt`=0 -> `pc`+1.
- Stall: hold `ex_done`=0 for 7 cycles after `ex_start` -> `pc` stable, `busy`=1, single `ex_start` pulse, `instr_count` unchanged until retire.
- Overrun, with `PROG_LEN`=8:
  - ADD at pc 7 -> HALTED, `err`=1, `pc`=7.
  - JMP with `target`=8 -> `err`=1.
  - JMP with `target`=0 -> `pc`=0, `err`=0.
- Restart and reset: `start` while HALTED -> `pc`=0, `instr_count`=0, `err`=0, FETCH next cycle. Then assert `rst_n`=0 mid-EXEC -> all outputs at reset values immediately and the instruction is not counted.
- Ignored start: pulse `start` during FETCH and during EXEC -> no effect on `pc`, state or `instr_count`.
